vector_argmax: RTL and testbench
================================

Name: vector_argmax

Overview:
- Streaming classifier head that sits directly downstream of a fully-connected layer stage.
- Consumes the layer's output stream of signed T-bit values, grouped as consecutive vectors of N elements.
- After each vector, emits the maximum value and its element index, i.e. the predicted class.
- Uses the same valid/ready handshake as the layer, so it connects straight to the layer's m_valid/m_ready/data_out.

Parameters:
- T, 16, data width in bits; all values are two's-complement signed.
- N, 16, elements per vector (the layer's output count); N >= 2.
- IW, $clog2(N), index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- s_valid  in  1  upstream element valid.
- m_ready  in  1  downstream ready for a result.
- data_in  in  T  signed input element.
- m_valid  out  1  result valid.
- s_ready  out  1  block can accept an element.
- data_out  out  T  signed maximum of the completed vector.
- idx_out  out  IW  index (0..N-1) of that maximum within the vector.

Behaviour:
- Reset (reset==0, asynchronous, takes effect immediately with no clock edge):
  - m_valid=0, data_out=0, idx_out=0.
  - Element counter=0, running max=0, running index=0.
  - s_ready follows its combinational rule, so it reads 1 while reset is held.
- Accept: an element transfers on a rising edge where s_valid && s_ready.
- Produce: a result transfers on a rising edge where m_valid && m_ready.
- s_ready = !m_valid || m_ready. Combinational, single-entry output register, no skid buffer.
- Element counter cnt:
  - Increments on each accept.
  - Wraps from N-1 to 0 on the last accept.
  - Never moves without an accept.
- Running comparison on accept with cnt==0: running max <= data_in, running index <= 0.
- Running comparison on accept with cnt>0: if data_in > running max (signed, strict), running max <= data_in and running index <= cnt.
  - Ties keep the earlier (lowest) index.
- Last element (accept with cnt==N-1):
  - The final compare is folded into the output load: data_out/idx_out <= winner of (running max, data_in) under the same strict rule.
  - m_valid <= 1 on the same edge.
  - Latency: result visible the cycle after the last element is accepted.
- Output hold: while m_valid && !m_ready, data_out, idx_out and m_valid are stable and s_ready=0.
- Output release: after a produce with no simultaneous last accept, m_valid <= 0. data_out/idx_out may hold their stale values.
- Simultaneous produce and last accept on one edge: the output reloads with the new result and m_valid stays 1. Full throughput is one element per cycle with no bubbles.
- Idle cycles: s_valid=0 mid-vector leaves the counter and running state unchanged, with no timeout.
- Reset mid-vector: the partial vector is discarded; the next accepted element is index 0 of a fresh vector.
- Reset with a pending result: the result is dropped and m_valid=0.
- Arithmetic: comparisons only, no overflow. Full T-bit signed compare, so -32768 is the minimum and 32767 the maximum.
- data_in is don't-care when s_valid=0; X on it must not corrupt state.

Decomposition:
- Shared package nn_pkg:
  - typedef data_t = logic signed [T-1:0].
  - Constants LAYER_T=16 and LAYER_N=16.
  - Function clog2-based idx width helper.
- One natural sub-module, argmax_cmp: combinational strict signed compare returning {max, idx}. It is reused for the running update and for the final fold.
- Counter, handshake and output register stay in the top.

Test Plan:
- Ascending vector 0,1,...,15 with s_valid and m_ready constantly 1 -> data_out=15, idx_out=15, m_valid high exactly one cycle after the 16th accept.
- Vector all -5 except element 7 = 100, followed back-to-back by an all-equal vector of 3s -> results (100,7), then (3,0) (tie to lowest index); no idle cycle between vectors.
- Signed extremes: element 0 = -32768, element 9 = 32767, others -1 -> (32767,9). An all -32768 vector -> (-32768,0).
- Backpressure: m_ready=0 when a result completes -> s_ready=0, result held unchanged for 20 cycles. Raising m_ready produces once; the next vector's elements are then accepted.
- Randomized s_valid/m_ready (50% each) across 625 vectors of 16 values, checked against a software reference model -> 625 results, zero mismatches, order preserved.
- reset driven low asynchronously after 5 elements of a vector -> m_valid=0 immediately. A following full vector with its max at index 2 returns idx_out=2, proving the counter restarted.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath blocks: layer geometry,
// the signed element type and the index-width helper.
package nn_pkg;

  // Geometry of the fully-connected layer feeding the classifier head.
  localparam int LAYER_T = 16;
  localparam int LAYER_N = 16;

  // One signed layer output element.
  typedef logic signed [LAYER_T-1:0] data_t;

  // Bits needed to hold an element index 0..n-1 (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Strict signed "keep the larger" compare of a running {max, idx} pair against
// a candidate. Ties keep the running pair, so the lowest index wins.
module argmax_cmp #(
  parameter int T  = 16,
  parameter int IW = 4
) (
  input  logic signed [T-1:0]  i_cur_max,
  input  logic        [IW-1:0] i_cur_idx,
  input  logic signed [T-1:0]  i_cand,
  input  logic        [IW-1:0] i_cand_idx,
  output logic signed [T-1:0]  o_max,
  output logic        [IW-1:0] o_idx
);

  // Select the candidate only when it is strictly greater than the running max.
  always_comb begin
    // NOTE: defaults are assigned first so every path drives both outputs and
    // no latch is inferred.
    o_max = i_cur_max;
    o_idx = i_cur_idx;
    if (i_cand > i_cur_max) begin
      o_max = i_cand;
      o_idx = i_cand_idx;
    end
  end

endmodule

// File: rtl/vector_argmax.sv
// Streaming argmax classifier head. Consumes N signed elements per vector over
// a valid/ready stream and emits {max, index} of each vector through a
// single-entry output register. Full throughput: one element per cycle, the
// next vector may start on the edge after the previous one's last element.
module vector_argmax
  import nn_pkg::*;
#(
  parameter  int T  = LAYER_T,
  parameter  int N  = LAYER_N,
  localparam int IW = idx_width(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  input  logic                m_ready,
  input  logic signed [T-1:0] data_in,
  output logic                m_valid,
  output logic                s_ready,
  output logic signed [T-1:0] data_out,
  output logic        [IW-1:0] idx_out
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  // Element position within the current vector and the running winner.
  logic        [IW-1:0] r_cnt;
  logic signed [T-1:0]  r_max;
  logic        [IW-1:0] r_idx;

  // Output register.
  logic                 r_m_valid;
  logic signed [T-1:0]  r_data_out;
  logic        [IW-1:0] r_idx_out;

  logic                 w_s_ready;
  logic                 w_accept;
  logic                 w_produce;
  logic                 w_last;
  logic                 w_first;
  logic signed [T-1:0]  w_cmp_max;
  logic        [IW-1:0] w_cmp_idx;

  // The output register can take a new result when empty or draining this edge.
  assign w_s_ready = !r_m_valid || m_ready;
  assign w_accept  = s_valid && w_s_ready;
  assign w_produce = r_m_valid && m_ready;
  assign w_first   = (r_cnt == '0);
  assign w_last    = (r_cnt == LAST_IDX);

  // One comparator serves both the running update and the final fold into the
  // output register; the candidate's index is simply its position in the vector.
  argmax_cmp #(
    .T  (T),
    .IW (IW)
  ) u_cmp (
    .i_cur_max  (r_max),
    .i_cur_idx  (r_idx),
    .i_cand     (data_in),
    .i_cand_idx (r_cnt),
    .o_max      (w_cmp_max),
    .o_idx      (w_cmp_idx)
  );

  // Track the element position and the running winner of the current vector.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values present before the edge.
    if (!reset) begin
      r_cnt <= '0;
      r_max <= '0;
      r_idx <= '0;
    end else if (w_accept) begin
      r_cnt <= w_last ? '0 : r_cnt + IW'(1);
      if (w_first) begin
        r_max <= data_in;
        r_idx <= '0;
      end else begin
        r_max <= w_cmp_max;
        r_idx <= w_cmp_idx;
      end
    end
  end

  // Load the final winner on the last element; clear valid once it is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m_valid  <= 1'b0;
      r_data_out <= '0;
      r_idx_out  <= '0;
    end else if (w_accept && w_last) begin
      r_m_valid  <= 1'b1;
      r_data_out <= w_cmp_max;
      r_idx_out  <= w_cmp_idx;
    end else if (w_produce) begin
      r_m_valid  <= 1'b0;
    end
  end

  assign s_ready  = w_s_ready;
  assign m_valid  = r_m_valid;
  assign data_out = r_data_out;
  assign idx_out  = r_idx_out;

endmodule

// File: tb/tb_vector_argmax.sv
// Self-checking bench for vector_argmax: directed vectors for the named
// corner cases plus a randomized handshake run against a reference model.
module tb_vector_argmax;
  import nn_pkg::*;

  localparam int T        = LAYER_T;
  localparam int N        = LAYER_N;
  localparam int IW       = 4;
  localparam int NUM_RAND = 625;

  typedef struct {
    int d;
    int i;
  } res_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          m_ready;
  data_t         data_in;
  logic          m_valid;
  logic          s_ready;
  data_t         data_out;
  logic [IW-1:0] idx_out;

  int n_tests = 0;
  int n_fail  = 0;
  int rdy_mode = 1;  // 0: m_ready low, 1: m_ready high, 2: random

  int   part_q[$];   // elements of the vector being collected
  res_t exp_q[$];    // expected results not yet produced
  res_t got_q[$];    // results the DUT has handed over

  bit p_last, p_rel, p_hold;
  int h_data, h_idx;

  vector_argmax #(
    .T (T),
    .N (N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .m_ready  (m_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .s_ready  (s_ready),
    .data_out (data_out),
    .idx_out  (idx_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: the largest value, then the first position holding it.
  function automatic res_t ref_argmax(input int v[$]);
    res_t r;
    int   mx;
    mx = v[0];
    foreach (v[k]) if (v[k] > mx) mx = v[k];
    r.d = mx;
    r.i = -1;
    foreach (v[k]) if (v[k] == mx && r.i < 0) r.i = k;
    return r;
  endfunction

  // Downstream ready generator, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: observes both handshakes on the falling edge, feeds the model
  // and checks results, latency, hold and release behaviour.
  always @(negedge clk) begin
    bit   acc, prod, last_acc;
    res_t e, g;
    if (!reset) begin
      part_q.delete();
      exp_q.delete();
      p_last = 1'b0;
      p_rel  = 1'b0;
      p_hold = 1'b0;
    end else begin
      if (p_last)     check("latency_mvalid", int'(m_valid), 1);
      else if (p_rel) check("release_mvalid", int'(m_valid), 0);
      if (p_hold) begin
        check("hold_mvalid", int'(m_valid), 1);
        check("hold_data", int'(data_out), h_data);
        check("hold_idx", int'(idx_out), h_idx);
      end
      if (!m_valid)      check("sready_empty", int'(s_ready), 1);
      else if (!m_ready) check("sready_stall", int'(s_ready), 0);

      acc      = s_valid && s_ready;
      prod     = m_valid && m_ready;
      last_acc = 1'b0;
      if (prod) begin
        g.d = int'(data_out);
        g.i = int'(idx_out);
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          check("unexpected_result", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("result_data", g.d, e.d);
          check("result_idx", g.i, e.i);
        end
      end
      if (acc) begin
        part_q.push_back(int'(data_in));
        if (part_q.size() == N) begin
          exp_q.push_back(ref_argmax(part_q));
          part_q.delete();
          last_acc = 1'b1;
        end
      end
      p_last = last_acc;
      p_rel  = prod && !last_acc;
      p_hold = m_valid && !m_ready;
      h_data = int'(data_out);
      h_idx  = int'(idx_out);
    end
  end

  // Present one element and hold it until it transfers; optional idle gaps.
  task automatic drive_elem(input int v, input bit gaps);
    int budget;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        s_valid = 1'b0;
        data_in = 'x;
        @(posedge clk); #1;
      end
    end
    s_valid = 1'b1;
    data_in = data_t'(v);
    budget  = 0;
    forever begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      budget++;
      if (budget > 2000) begin
        check("drive_timeout", int'(s_ready), 1);
        break;
      end
    end
  endtask

  task automatic drive_vector(input int vals[N], input bit gaps);
    for (int k = 0; k < N; k++) drive_elem(vals[k], gaps);
    s_valid = 1'b0;
    data_in = 'x;
  endtask

  // Wait until every expected result has been produced and valid has dropped.
  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_valid) done = 1'b1;
    end
    if (!done) check("drain_timeout", exp_q.size() + int'(m_valid), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_mvalid();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (m_valid) done = 1'b1;
    end
    if (!done) check("mvalid_timeout", int'(m_valid), 1);
  endtask

  task automatic expect_got(input string tag, input int d, input int i);
    res_t g;
    if (got_q.size() == 0) begin
      check({tag, "_missing"}, got_q.size(), 1);
    end else begin
      g = got_q.pop_front();
      check({tag, "_data"}, g.d, d);
      check({tag, "_idx"}, g.i, i);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check("rst_mvalid", int'(m_valid), 0);
    check("rst_data", int'(data_out), 0);
    check("rst_idx", int'(idx_out), 0);
    check("rst_sready", int'(s_ready), 1);
    @(negedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    vals[N];
    data_t tmp;
    int    mode;

    reset   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    data_in = '0;

    // Reset state before any clock edge.
    #1;
    check("init_mvalid", int'(m_valid), 0);
    check("init_data", int'(data_out), 0);
    check("init_idx", int'(idx_out), 0);
    check("init_sready", int'(s_ready), 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // Ascending vector, back-to-back with constant ready.
    for (int k = 0; k < N; k++) vals[k] = k;
    drive_vector(vals, 1'b0);
    wait_drain();
    check("asc_count", got_q.size(), 1);
    expect_got("asc", 15, 15);

    // Single peak followed immediately by an all-equal vector.
    for (int k = 0; k < N; k++) vals[k] = (k == 7) ? 100 : -5;
    drive_vector(vals, 1'b0);
    for (int k = 0; k < N; k++) vals[k] = 3;
    drive_vector(vals, 1'b0);
    wait_drain();
    expect_got("peak", 100, 7);
    expect_got("tie", 3, 0);

    // Signed extremes.
    for (int k = 0; k < N; k++) vals[k] = (k == 0) ? -32768 : (k == 9) ? 32767 : -1;
    drive_vector(vals, 1'b0);
    for (int k = 0; k < N; k++) vals[k] = -32768;
    drive_vector(vals, 1'b0);
    wait_drain();
    expect_got("extreme", 32767, 9);
    expect_got("all_min", -32768, 0);

    // Backpressure: result held for 20 cycles, then taken exactly once.
    rdy_mode = 0;
    m_ready  = 1'b0;
    for (int k = 0; k < N; k++) vals[k] = (k == 5) ? 1000 : 3 * k;
    drive_vector(vals, 1'b0);
    wait_mvalid();
    for (int c = 0; c < 20; c++) begin
      check("bp_sready", int'(s_ready), 0);
      check("bp_data", int'(data_out), 1000);
      check("bp_idx", int'(idx_out), 5);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rdy_mode = 1;
    m_ready  = 1'b1;
    for (int k = 0; k < N; k++) vals[k] = (k == 11) ? 8 : 7;
    drive_vector(vals, 1'b0);
    wait_drain();
    check("bp_count", got_q.size(), 2);
    expect_got("bp_first", 1000, 5);
    expect_got("bp_next", 8, 11);

    // Reset while a result is pending drops it.
    rdy_mode = 0;
    m_ready  = 1'b0;
    for (int k = 0; k < N; k++) vals[k] = 20 - k;
    drive_vector(vals, 1'b0);
    wait_mvalid();
    pulse_reset();
    rdy_mode = 1;
    m_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_drop_count", got_q.size(), 0);

    // Reset mid-vector restarts the element counter.
    for (int k = 0; k < 5; k++) drive_elem(500 + k, 1'b0);
    s_valid = 1'b0;
    pulse_reset();
    for (int k = 0; k < N; k++) vals[k] = (k == 2) ? 50 : -k;
    drive_vector(vals, 1'b0);
    wait_drain();
    check("restart_count", got_q.size(), 1);
    expect_got("restart", 50, 2);

    // Randomized stream with random gaps and backpressure.
    got_q.delete();
    rdy_mode = 2;
    for (int v = 0; v < NUM_RAND; v++) begin
      mode = int'($urandom_range(0, 3));
      for (int k = 0; k < N; k++) begin
        if (mode == 0) begin
          vals[k] = int'($urandom_range(0, 4)) - 2;
        end else if (mode == 1) begin
          case ($urandom_range(0, 2))
            0:       vals[k] = -32768;
            1:       vals[k] = 32767;
            default: vals[k] = 0;
          endcase
        end else begin
          tmp     = data_t'($urandom);
          vals[k] = int'(tmp);
        end
      end
      drive_vector(vals, 1'b1);
    end
    rdy_mode = 1;
    wait_drain();
    check("rand_count", got_q.size(), NUM_RAND);
    check("rand_leftover", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
